fir_stream: RTL and testbench

Parametrised streaming FIR engine: TAP_NUM signed coefficients and the control/status registers are programmed over AXI-Lite, samples arrive on an AXI-Stream slave, and filtered results leave on an AXI-Stream master. It is the generalised successor of the lab FIR block. Coefficients and the sample history live in internal registers, so no external tap or data BRAM is needed. The MAC is sequential, one tap per cycle. The block also adds tap-count and width parameters, sample-count/tlast checking, and optional output saturation.

---
 rtl/fir_stream.sv | 224 ++++++++++++++++++++++
 tb/tb_fir_stream.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream.sv
// Streaming FIR: AXI-Lite programmed taps/control, AXI-Stream in/out, one MAC per cycle.
// Optional FIR_OUT_SAT_EN: saturate the output to the signed DATA_W range instead of wrapping.
module fir_stream #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TAP_NUM = 11
) (
  input  logic              axis_clk,
  input  logic              axis_rst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  input  logic              ss_tvalid,
  output logic              ss_tready,
  input  logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tlast,
  output logic              sm_tvalid,
  input  logic              sm_tready,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast
);

  localparam int ACC_W = 2 * DATA_W + $clog2(TAP_NUM);
  localparam int IDX_W = $clog2(TAP_NUM);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] LEN_ADDR  = ADDR_W'(32'h10);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_GET, S_MAC, S_PUT, S_DONE} state_t;

  state_t                   state_reg, state_next;
  logic signed [DATA_W-1:0] tap_reg  [TAP_NUM];
  logic signed [DATA_W-1:0] hist_reg [TAP_NUM];
  logic [DATA_W-1:0]        len_reg;
  logic [DATA_W-1:0]        cnt_reg;
  logic                     start_reg;
  logic                     done_reg;
  logic                     tlast_err_reg;
  logic [IDX_W-1:0]         mac_idx_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [DATA_W-1:0]        out_reg;
  logic                     last_reg;
  logic                     rvalid_reg;
  logic [DATA_W-1:0]        rdata_reg;

  logic                       wr_en, rd_en, ap_idle, is_last, sample_take, beat_take;
  logic [DATA_W-1:0]          ctrl_word, rd_word, out_word;
  logic signed [DATA_W-1:0]   tap_sel, hist_sel;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_sum;

  // AXI-Lite handshakes: a write needs address and data together and commits that cycle
  assign wr_en   = awvalid && wvalid && !axis_rst;
  assign awready = wr_en;
  assign wready  = wr_en;
  assign arready = !rvalid_reg && !axis_rst;
  assign rd_en   = arvalid && arready;
  assign rvalid  = rvalid_reg;
  assign rdata   = rdata_reg;

  assign ap_idle     = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign is_last     = (cnt_reg == len_reg - DATA_W'(1));
  assign sample_take = (state_reg == S_GET) && ss_tvalid;
  assign beat_take   = (state_reg == S_PUT) && sm_tready;
  assign ctrl_word   = {{(DATA_W-4){1'b0}}, tlast_err_reg, ap_idle, done_reg, start_reg};

  assign ss_tready = (state_reg == S_GET);
  assign sm_tvalid = (state_reg == S_PUT);
  assign sm_tlast  = (state_reg == S_PUT) && last_reg;
  assign sm_tdata  = out_reg;

  always_comb begin
    rd_word = '0;
    if (araddr == CTRL_ADDR) begin
      rd_word = ctrl_word;
    end else if (araddr == LEN_ADDR) begin
      rd_word = len_reg;
    end else begin
      for (int i = 0; i < TAP_NUM; i++) begin
        if (araddr == ADDR_W'(32 + 4 * i)) rd_word = tap_reg[i];
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else if (rd_en) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_word;
    end else if (rvalid_reg && rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  // Coefficients: writes only land while idle
  for (genvar gi = 0; gi < TAP_NUM; gi++) begin : g_tap
    localparam logic [ADDR_W-1:0] TAP_ADDR = ADDR_W'(32 + 4 * gi);
    always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
        tap_reg[gi] <= '0;
      end else if (wr_en && ap_idle && awaddr == TAP_ADDR) begin
        tap_reg[gi] <= wdata;
      end
    end
  end

  // Sample history, newest sample in slot 0
  for (genvar gi = 0; gi < TAP_NUM; gi++) begin : g_hist
    localparam int SRC = (gi == 0) ? 0 : gi - 1;
    always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
        hist_reg[gi] <= '0;
      end else if (state_reg == S_CLR) begin
        hist_reg[gi] <= '0;
      end else if (sample_take) begin
        hist_reg[gi] <= (gi == 0) ? $signed(ss_tdata) : hist_reg[SRC];
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      len_reg       <= '0;
      start_reg     <= 1'b0;
      done_reg      <= 1'b0;
      tlast_err_reg <= 1'b0;
    end else begin
      if (wr_en && ap_idle && awaddr == LEN_ADDR) len_reg <= wdata;

      if (state_reg == S_IDLE && start_reg) begin
        start_reg <= 1'b0;
      end else if (wr_en && ap_idle && awaddr == CTRL_ADDR && wdata[0]) begin
        start_reg <= 1'b1;
      end

      // A done set in the same cycle as a clearing read takes priority
      if (state_next == S_DONE && state_reg != S_DONE) begin
        done_reg <= 1'b1;
      end else if (rd_en && araddr == CTRL_ADDR) begin
        done_reg <= 1'b0;
      end

      if (state_reg == S_CLR) begin
        tlast_err_reg <= 1'b0;
      end else if (sample_take && (ss_tlast != is_last)) begin
        tlast_err_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start_reg) state_next = S_CLR;
      S_CLR:  state_next = (len_reg == '0) ? S_DONE : S_GET;
      S_GET:  if (ss_tvalid) state_next = S_MAC;
      S_MAC:  if (mac_idx_reg == IDX_W'(TAP_NUM - 1)) state_next = S_PUT;
      S_PUT:  if (sm_tready) state_next = is_last ? S_DONE : S_GET;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign tap_sel  = tap_reg[mac_idx_reg];
  assign hist_sel = hist_reg[mac_idx_reg];
  assign prod     = (2*DATA_W)'(tap_sel) * (2*DATA_W)'(hist_sel);
  assign acc_sum  = acc_reg + ACC_W'(prod);

`ifdef FIR_OUT_SAT_EN
  always_comb begin
    if ((&acc_sum[ACC_W-1:DATA_W-1]) || !(|acc_sum[ACC_W-1:DATA_W-1])) begin
      out_word = acc_sum[DATA_W-1:0];
    end else if (acc_sum[ACC_W-1]) begin
      out_word = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      out_word = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign out_word = acc_sum[DATA_W-1:0];
`endif

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      acc_reg     <= '0;
      mac_idx_reg <= '0;
      cnt_reg     <= '0;
      out_reg     <= '0;
      last_reg    <= 1'b0;
    end else begin
      if (state_reg == S_CLR) cnt_reg <= '0;
      else if (beat_take)     cnt_reg <= cnt_reg + DATA_W'(1);

      if (sample_take) begin
        acc_reg     <= '0;
        mac_idx_reg <= '0;
      end else if (state_reg == S_MAC) begin
        acc_reg     <= acc_sum;
        mac_idx_reg <= mac_idx_reg + IDX_W'(1);
        // Result is captured on the final tap so it is ready on entry to PUT
        if (mac_idx_reg == IDX_W'(TAP_NUM - 1)) begin
          out_reg  <= out_word;
          last_reg <= is_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_stream.sv
// Self-checking bench for fir_stream: register table, directed frames, randomized frames
// against a plain-arithmetic convolution model (honours FIR_OUT_SAT_EN).
`timescale 1ns/1ps
module tb_fir_stream;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TAP_NUM = 11;

  typedef logic signed [DATA_W-1:0] word_t;
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp;
  } reg_vec_t;

  localparam logic signed [127:0] Y_MAX = (128'sd1 <<< (DATA_W - 1)) - 128'sd1;
  localparam logic signed [127:0] Y_MIN = -(128'sd1 <<< (DATA_W - 1));

  logic axis_clk = 1'b0;
  logic axis_rst = 1'b1;
  logic awvalid = 0, wvalid = 0, arvalid = 0, rready = 0;
  logic awready, wready, arready, rvalid;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
  logic [DATA_W-1:0] wdata = '0, rdata;
  logic ss_tvalid = 0, ss_tlast = 0, sm_tready = 0;
  logic ss_tready, sm_tvalid, sm_tlast;
  logic [DATA_W-1:0] ss_tdata = '0, sm_tdata;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  word_t h_m [TAP_NUM];
  word_t xq[$];
  int    hs_cyc[$];
  int    tl_pos, gap_max, stall_lo, stall_hi;

  fir_stream #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAP_NUM(TAP_NUM)) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
  );

  always #5 axis_clk = ~axis_clk;
  always @(posedge axis_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, required 0x%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, required %b", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout, required handshake", nm);
  endtask

  // Reference: direct convolution with wide integers, then wrap or saturate
  function automatic logic [DATA_W-1:0] ref_y(input word_t xs[$], input int n);
    logic signed [127:0] s;
    s = '0;
    for (int i = 0; i < TAP_NUM; i++) begin
      if (n - i >= 0) s += 128'(h_m[i]) * 128'(xs[n - i]);
    end
`ifdef FIR_OUT_SAT_EN
    if (s > Y_MAX) s = Y_MAX;
    if (s < Y_MIN) s = Y_MIN;
`endif
    return s[DATA_W-1:0];
  endfunction

  task automatic axil_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    @(negedge axis_clk);
    chk("aw/w ready", {30'd0, awready, wready}, 32'd3);
    @(posedge axis_clk); #1;
    awvalid = 0; wvalid = 0;
    $display("wr 0x%h <= 0x%h", a, d);
  endtask

  task automatic axil_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    bit ok;
    d = '0;
    araddr = a; arvalid = 1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge axis_clk);
      if (arready) begin ok = 1; break; end
    end
    @(posedge axis_clk); #1;
    arvalid = 0;
    if (!ok) begin timeout("arready"); return; end
    rready = 1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge axis_clk);
      if (rvalid) begin ok = 1; d = rdata; break; end
    end
    @(posedge axis_clk); #1;
    rready = 0;
    if (!ok) timeout("rvalid");
    $display("rd 0x%h -> 0x%h", a, d);
  endtask

  task automatic read_chk(input string nm, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    logic [DATA_W-1:0] d;
    axil_read(a, d);
    chk(nm, d, exp);
  endtask

  task automatic set_taps();
    for (int i = 0; i < TAP_NUM; i++) axil_write(ADDR_W'(32 + 4 * i), h_m[i]);
  endtask

  task automatic send_all();
    int g;
    bit ok;
    for (int i = 0; i < xq.size(); i++) begin
      g = $urandom_range(0, gap_max);
      if (g > 0) begin repeat (g) @(posedge axis_clk); #1; end
      ss_tvalid = 1; ss_tdata = xq[i]; ss_tlast = (i == tl_pos);
      ok = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge axis_clk);
        if (ss_tready) begin ok = 1; break; end
      end
      if (!ok) begin timeout("ss_tready"); ss_tvalid = 0; return; end
      hs_cyc.push_back(cyc);
      @(posedge axis_clk); #1;
      ss_tvalid = 0; ss_tlast = 0;
    end
  endtask

  task automatic collect_all(input int n);
    bit ok;
    int st;
    logic [DATA_W-1:0] exp;
    for (int j = 0; j < n; j++) begin
      ok = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge axis_clk);
        if (sm_tvalid) begin ok = 1; break; end
      end
      if (!ok) begin timeout("sm_tvalid"); return; end
      if (j < hs_cyc.size()) chk("latency", 32'(cyc - hs_cyc[j]), 32'(TAP_NUM + 1));
      else timeout("ss handshake before output");
      exp = ref_y(xq, j);
      st = $urandom_range(stall_lo, stall_hi);
      for (int k = 0; k < st; k++) begin
        chk("sm_tdata stalled", sm_tdata, exp);
        chk1("sm_tvalid stalled", sm_tvalid, 1'b1);
        chk1("ss_tready in PUT", ss_tready, 1'b0);
        @(negedge axis_clk);
      end
      chk("sm_tdata", sm_tdata, exp);
      chk1("sm_tlast", sm_tlast, j == n - 1);
      chk1("sm_tvalid", sm_tvalid, 1'b1);
      sm_tready = 1;
      @(posedge axis_clk); #1;
      sm_tready = 0;
      $display("beat %0d y=0x%h stall=%0d", j, exp, st);
    end
  endtask

  task automatic run_frame(input int n, input int tl, input int g, input int s_lo, input int s_hi);
    hs_cyc.delete();
    tl_pos = tl; gap_max = g; stall_lo = s_lo; stall_hi = s_hi;
    fork
      send_all();
      collect_all(n);
    join
  endtask

  reg_vec_t rtab [16];
  logic [DATA_W-1:0] rd;
  int n_len;
  bit ok;

  initial begin
    rtab[0]  = '{wr:1'b0, addr:12'h000, data:32'h0,         exp:32'h4};
    rtab[1]  = '{wr:1'b0, addr:12'h020, data:32'h0,         exp:32'h0};
    rtab[2]  = '{wr:1'b0, addr:12'h010, data:32'h0,         exp:32'h0};
    rtab[3]  = '{wr:1'b1, addr:12'h010, data:32'h5,         exp:32'h0};
    rtab[4]  = '{wr:1'b0, addr:12'h010, data:32'h0,         exp:32'h5};
    rtab[5]  = '{wr:1'b1, addr:12'h024, data:32'h2,         exp:32'h0};
    rtab[6]  = '{wr:1'b0, addr:12'h024, data:32'h0,         exp:32'h2};
    rtab[7]  = '{wr:1'b1, addr:12'h048, data:32'hB,         exp:32'h0};
    rtab[8]  = '{wr:1'b0, addr:12'h048, data:32'h0,         exp:32'hB};
    rtab[9]  = '{wr:1'b0, addr:12'h04C, data:32'h0,         exp:32'h0};
    rtab[10] = '{wr:1'b1, addr:12'h014, data:32'hDEADBEEF,  exp:32'h0};
    rtab[11] = '{wr:1'b0, addr:12'h014, data:32'h0,         exp:32'h0};
    rtab[12] = '{wr:1'b0, addr:12'h010, data:32'h0,         exp:32'h5};
    rtab[13] = '{wr:1'b1, addr:12'h000, data:32'h0,         exp:32'h0};
    rtab[14] = '{wr:1'b0, addr:12'h000, data:32'h0,         exp:32'h4};
    rtab[15] = '{wr:1'b0, addr:12'hFFC, data:32'h0,         exp:32'h0};

    // Reset: handshakes must stay low even with requests pending
    repeat (2) @(posedge axis_clk); #1;
    awvalid = 1; wvalid = 1; arvalid = 1; awaddr = 12'h020; wdata = 32'h55;
    @(negedge axis_clk);
    chk1("reset awready", awready, 1'b0);
    chk1("reset wready", wready, 1'b0);
    chk1("reset arready", arready, 1'b0);
    chk1("reset rvalid", rvalid, 1'b0);
    chk("reset rdata", rdata, 32'h0);
    chk1("reset ss_tready", ss_tready, 1'b0);
    chk1("reset sm_tvalid", sm_tvalid, 1'b0);
    chk("reset sm_tdata", sm_tdata, 32'h0);
    chk1("reset sm_tlast", sm_tlast, 1'b0);
    #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(posedge axis_clk); #1;
    axis_rst = 0;
    @(posedge axis_clk); #1;

    for (int i = 0; i < 16; i++) begin
      if (rtab[i].wr) axil_write(rtab[i].addr, rtab[i].data);
      else read_chk($sformatf("regtab[%0d]", i), rtab[i].addr, rtab[i].exp);
    end

    // Frame 1: h[i] = i+1, x = 1..5
    for (int i = 0; i < TAP_NUM; i++) h_m[i] = word_t'(i + 1);
    set_taps();
    axil_write(12'h010, 32'd5);
    xq.delete();
    for (int i = 1; i <= 5; i++) xq.push_back(word_t'(i));
    axil_write(12'h000, 32'h1);
    run_frame(5, 4, 0, 0, 0);
    read_chk("ctrl after frame1", 12'h000, 32'h6);
    read_chk("ctrl after done read", 12'h000, 32'h4);

    // Frame 2: 5-cycle output stalls, ss_tlast early on sample 3
    xq.delete();
    for (int i = 0; i < 5; i++) xq.push_back(word_t'(int'($urandom_range(0, 2000)) - 1000));
    axil_write(12'h000, 32'h1);
    run_frame(5, 2, 0, 5, 5);
    read_chk("ctrl tlast_err", 12'h000, 32'hE);
    read_chk("ctrl tlast_err sticky", 12'h000, 32'hC);

    // Randomized frames, full-range values on the first two
    for (int f = 0; f < 4; f++) begin
      n_len = $urandom_range(1, 8);
      for (int i = 0; i < TAP_NUM; i++)
        h_m[i] = (f < 2) ? word_t'($urandom) : word_t'(int'($urandom_range(0, 200)) - 100);
      set_taps();
      axil_write(12'h010, 32'(n_len));
      xq.delete();
      for (int i = 0; i < n_len; i++) xq.push_back(word_t'($urandom));
      axil_write(12'h000, 32'h1);
      run_frame(n_len, n_len - 1, 2, 0, 2);
      read_chk("ctrl after random frame", 12'h000, 32'h6);
    end

    // Writes while busy are dropped; start while busy ignored
    for (int i = 0; i < TAP_NUM; i++) h_m[i] = word_t'(int'($urandom_range(0, 40)) - 20);
    set_taps();
    axil_write(12'h010, 32'd3);
    axil_write(12'h000, 32'h1);
    repeat (3) @(posedge axis_clk); #1;
    axil_write(12'h020, 32'd9);
    axil_write(12'h010, 32'd7);
    axil_write(12'h000, 32'h1);
    read_chk("tap0 busy write", 12'h020, h_m[0]);
    read_chk("len busy write", 12'h010, 32'd3);
    read_chk("ctrl busy", 12'h000, 32'h0);
    xq.delete();
    for (int i = 0; i < 3; i++) xq.push_back(word_t'(int'($urandom_range(0, 100)) - 50));
    run_frame(3, 2, 1, 0, 1);
    read_chk("ctrl after busy frame", 12'h000, 32'h6);
    read_chk("ctrl no restart", 12'h000, 32'h4);

    // data_length = 0: done with no stream activity
    axil_write(12'h010, 32'd0);
    axil_write(12'h000, 32'h1);
    for (int k = 0; k < 2; k++) begin
      @(negedge axis_clk);
      chk1("len0 ss_tready", ss_tready, 1'b0);
      chk1("len0 sm_tvalid", sm_tvalid, 1'b0);
      @(posedge axis_clk); #1;
    end
    read_chk("ctrl len0 done", 12'h000, 32'h6);

    // Output saturation / wrap boundaries
    for (int i = 0; i < TAP_NUM; i++) h_m[i] = '0;
    h_m[0] = word_t'(32'h7FFFFFFF);
    set_taps();
    axil_write(12'h010, 32'd1);
    xq.delete(); xq.push_back(word_t'(2));
    axil_write(12'h000, 32'h1);
`ifdef FIR_OUT_SAT_EN
    chk("sat model positive", ref_y(xq, 0), 32'h7FFFFFFF);
`else
    chk("wrap model positive", ref_y(xq, 0), 32'hFFFFFFFE);
`endif
    run_frame(1, 0, 0, 0, 0);
    read_chk("ctrl after sat frame", 12'h000, 32'h6);
    h_m[0] = word_t'(32'h80000000);
    axil_write(12'h020, h_m[0]);
    axil_write(12'h000, 32'h1);
    run_frame(1, 0, 0, 0, 0);
    read_chk("ctrl after neg sat frame", 12'h000, 32'h6);

    // Reset in the middle of MAC
    for (int i = 0; i < TAP_NUM; i++) h_m[i] = word_t'(i + 3);
    set_taps();
    axil_write(12'h010, 32'd3);
    axil_write(12'h000, 32'h1);
    ss_tvalid = 1; ss_tdata = 32'd5; ss_tlast = 0;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge axis_clk);
      if (ss_tready) begin ok = 1; break; end
    end
    if (!ok) timeout("ss_tready before reset");
    @(posedge axis_clk); #1;
    ss_tvalid = 0;
    read_chk("tap1 before reset", 12'h024, 32'd4);
    axis_rst = 1; arvalid = 1; araddr = 12'h020;
    @(negedge axis_clk);
    chk1("midrst arready", arready, 1'b0);
    chk1("midrst rvalid", rvalid, 1'b0);
    chk("midrst rdata", rdata, 32'h0);
    chk1("midrst ss_tready", ss_tready, 1'b0);
    chk1("midrst sm_tvalid", sm_tvalid, 1'b0);
    chk("midrst sm_tdata", sm_tdata, 32'h0);
    chk1("midrst sm_tlast", sm_tlast, 1'b0);
    #1;
    arvalid = 0;
    @(posedge axis_clk); #1;
    axis_rst = 0;
    @(posedge axis_clk); #1;
    read_chk("ctrl after midrst", 12'h000, 32'h4);
    read_chk("tap0 after midrst", 12'h020, 32'h0);
    read_chk("tap10 after midrst", 12'h048, 32'h0);
    read_chk("len after midrst", 12'h010, 32'h0);
    @(negedge axis_clk);
    chk1("idle sm_tvalid after midrst", sm_tvalid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
